// File: rtl/seg7_pkg.sv
// Shared glyph table, nibble-to-glyph lookup and load-FSM state type for the
// two-digit 7-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  localparam int DEFAULT_SCAN_DIV = 50000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEX  = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } load_state_e;

  function automatic logic [6:0] nib2seg(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd8_seq.sv
// Sequential 8-bit binary to BCD converter (shift-add-3), one bit per clock.
// The start edge consumes the MSB; done_o pulses 8 cycles after start.
module bin2bcd8_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start_i,
  input  logic [7:0] bin_i,
  output logic       done_o,
  output logic [3:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [7:0]  sh_q, sh_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] adj;
  logic [2:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;

  always_comb begin
    adj    = bcd_q;
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (bcd_q[3:0]  >= 4'd5) adj[3:0]  = bcd_q[3:0]  + 4'd3;
    if (bcd_q[7:4]  >= 4'd5) adj[7:4]  = bcd_q[7:4]  + 4'd3;
    if (bcd_q[11:8] >= 4'd5) adj[11:8] = bcd_q[11:8] + 4'd3;
    if (start_i) begin
      // BCD starts at zero, so the first shift needs no add-3 correction.
      {bcd_d, sh_d} = {12'd0, bin_i} << 1;
      cnt_d = 3'd1;
      run_d = 1'b1;
    end else if (run_q) begin
      {bcd_d, sh_d} = {adj, sh_q} << 1;
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign hund_o = bcd_q[11:8];
  assign tens_o = bcd_q[7:4];
  assign ones_o = bcd_q[3:0];

endmodule

// File: rtl/seg7_scan_driver.sv
// Latches an 8-bit value, converts it to two hex or decimal glyphs and scans
// them onto a multiplexed two-digit 7-segment display.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = DEFAULT_SCAN_DIV,
  parameter int DIV_WIDTH = 16,
  parameter bit LZ_BLANK  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD,
  input  logic [7:0]  VAL,
  input  logic        DEC,
  output logic        BUSY,
  output logic        OVF,
  output logic [6:0]  SEG,
  output logic        D1,
  output logic        D2,
  output load_state_e dbg_state_o
);

  // Handshake: LOAD is taken on an edge where BUSY is low (IDLE or DONE);
  // BUSY is high from the next cycle until the edge that commits the digits.
  // LOAD seen while BUSY is high, including the commit edge, is dropped.

  load_state_e state_q, state_d;
  logic [7:0]  val_q, val_d;
  logic        conv_start, commit_hex, commit_dec;

  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic                 sel_q, sel_d;
  logic                 wrap;
  logic                 d1_q, d1_d, d2_q;
  logic [6:0]           seg_q, seg_d;
  logic [6:0]           hi_q, hi_d, lo_q, lo_d;
  logic                 ovf_q, ovf_d;

  logic       bcd_done;
  logic [3:0] bcd_hund, bcd_tens, bcd_ones;

  bin2bcd8_seq u_bcd (
    .CLK     (CLK),
    .RST     (RST),
    .start_i (conv_start),
    .bin_i   (VAL),
    .done_o  (bcd_done),
    .hund_o  (bcd_hund),
    .tens_o  (bcd_tens),
    .ones_o  (bcd_ones)
  );

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    conv_start = 1'b0;
    commit_hex = 1'b0;
    commit_dec = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (LOAD) begin
          val_d      = VAL;
          conv_start = DEC;
          state_d    = DEC ? ST_CONV : ST_HEX;
        end
      end
      ST_HEX: begin
        commit_hex = 1'b1;
        state_d    = ST_DONE;
      end
      ST_CONV: begin
        if (bcd_done) begin
          commit_dec = 1'b1;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sel_q=0 selects the tens digit; D1 follows sel one edge later.
  always_comb begin
    wrap    = (presc_q == DIV_WIDTH'(SCAN_DIV - 1));
    presc_d = wrap ? '0 : presc_q + DIV_WIDTH'(1);
    sel_d   = wrap ? ~sel_q : sel_q;
    d1_d    = ~sel_q;
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    ovf_d = ovf_q;
    if (commit_hex) begin
      hi_d  = nib2seg(val_q[7:4]);
      lo_d  = nib2seg(val_q[3:0]);
      ovf_d = 1'b0;
    end else if (commit_dec) begin
      if (bcd_hund != 4'd0) begin
        hi_d  = SEG_DASH;
        lo_d  = SEG_DASH;
        ovf_d = 1'b1;
      end else begin
        hi_d  = (LZ_BLANK && (bcd_tens == 4'd0)) ? SEG_BLANK : nib2seg(bcd_tens);
        lo_d  = nib2seg(bcd_ones);
        ovf_d = 1'b0;
      end
    end
    // Use next-state values so SEG, D1/D2 and new digits land on one edge.
    seg_d = d1_d ? hi_d : lo_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      presc_q <= '0;
      sel_q   <= 1'b0;
      d1_q    <= 1'b1;
      d2_q    <= 1'b0;
      seg_q   <= SEG_BLANK;
      hi_q    <= SEG_BLANK;
      lo_q    <= SEG_BLANK;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      d1_q    <= d1_d;
      d2_q    <= ~d1_d;
      seg_q   <= seg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ovf_q   <= ovf_d;
    end
  end

  assign BUSY        = (state_q == ST_HEX) || (state_q == ST_CONV);
  assign OVF         = ovf_q;
  assign SEG         = seg_q;
  assign D1          = d1_q;
  assign D2          = d2_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a short scan period: table of
// loads plus hand sequences for collision, falling-BUSY load and reset abort.
module tb_seg7_scan_driver;
  import seg7_pkg::*;

  localparam int SD = 4;
  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst, load, dec;
  logic [7:0]  val;
  logic        busy, ovf, d1, d2;
  logic [6:0]  seg;
  load_state_e dbg_state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] val;
    logic       dec;
    logic [6:0] hi;
    logic [6:0] lo;
    logic       ovf;
  } vec_t;

  vec_t vec[NV];

  seg7_scan_driver #(.SCAN_DIV(SD), .DIV_WIDTH(16), .LZ_BLANK(1'b1)) dut (
    .CLK         (clk),
    .RST         (rst),
    .LOAD        (load),
    .VAL         (val),
    .DEC         (dec),
    .BUSY        (busy),
    .OVF         (ovf),
    .SEG         (seg),
    .D1          (d1),
    .D2          (d2),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scan model: k counts edges since the last reset edge.
  function automatic logic exp_d1(input int k);
    if (k == 0) return 1'b1;
    return (((k - 1) / SD) % 2) == 0;
  endfunction

  int   scan_k  = 0;
  logic scan_en = 1'b0;
  logic scan_r;
  logic scan_e;

  always @(posedge clk) begin
    scan_r = rst;
    #1;
    if (scan_r) scan_k = 0;
    else scan_k = scan_k + 1;
    if (scan_en) begin
      scan_e = exp_d1(scan_k);
      chk("d1_scan", d1, scan_e);
      chk("d2_scan", d2, !scan_e);
    end
  end

  // driver tasks
  task automatic do_load(input logic [7:0] v, input logic d);
    load = 1'b1;
    val  = v;
    dec  = d;
    tick();
    load = 1'b0;
    val  = 8'($urandom_range(0, 255));
    dec  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_busy(input logic [6:0] hi, input logic [6:0] lo, input logic o,
                           output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk("seg_during_busy", seg, d1 ? hi : lo);
      chk("ovf_during_busy", ovf, o);
      n++;
      tick();
    end
    if (n >= 40) chk("busy_timeout", 1, 0);
  endtask

  task automatic check_disp(input logic [6:0] hi, input logic [6:0] lo, input logic o,
                            input int cycles);
    for (int c = 0; c < cycles; c++) begin
      chk("seg", seg, d1 ? hi : lo);
      chk("ovf", ovf, o);
      chk("busy_idle", busy, 0);
      tick();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_d1"}, d1, 1);
    chk({tag, "_d2"}, d2, 0);
    chk({tag, "_seg"}, seg, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  logic [6:0] cur_hi, cur_lo;
  logic       cur_ovf;
  int         n;

  initial begin
    vec[0]  = '{8'h3C, 1'b0, 7'b1111001, 7'b1001110, 1'b0};
    vec[1]  = '{8'd42, 1'b1, 7'b0110011, 7'b1101101, 1'b0};
    vec[2]  = '{8'd7,  1'b1, 7'b0000000, 7'b1110000, 1'b0};
    vec[3]  = '{8'd200,1'b1, 7'b0000001, 7'b0000001, 1'b1};
    vec[4]  = '{8'hC8, 1'b0, 7'b1001110, 7'b1111111, 1'b0};
    vec[5]  = '{8'd99, 1'b1, 7'b1111011, 7'b1111011, 1'b0};
    vec[6]  = '{8'hAF, 1'b0, 7'b1110111, 7'b1000111, 1'b0};
    vec[7]  = '{8'd0,  1'b1, 7'b0000000, 7'b1111110, 1'b0};
    vec[8]  = '{8'hB5, 1'b0, 7'b0011111, 7'b1011011, 1'b0};
    vec[9]  = '{8'd10, 1'b1, 7'b0110000, 7'b1111110, 1'b0};
    vec[10] = '{8'd255,1'b1, 7'b0000001, 7'b0000001, 1'b1};
    vec[11] = '{8'hDE, 1'b0, 7'b0111101, 7'b1001111, 1'b0};
    vec[12] = '{8'h06, 1'b0, 7'b1111110, 7'b1011111, 1'b0};
    vec[13] = '{8'd100,1'b1, 7'b0000001, 7'b0000001, 1'b1};

    rst  = 1'b1;
    load = 1'b0;
    val  = 8'h00;
    dec  = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    scan_en = 1'b1;
    rst = 1'b0;
    check_disp(7'b0000000, 7'b0000000, 1'b0, 2 * SD);

    cur_hi  = 7'b0000000;
    cur_lo  = 7'b0000000;
    cur_ovf = 1'b0;
    for (int i = 0; i < NV; i++) begin
      do_load(vec[i].val, vec[i].dec);
      wait_busy(cur_hi, cur_lo, cur_ovf, n);
      chk("busy_len", n, vec[i].dec ? 8 : 1);
      check_disp(vec[i].hi, vec[i].lo, vec[i].ovf, 2 * SD);
      cur_hi  = vec[i].hi;
      cur_lo  = vec[i].lo;
      cur_ovf = vec[i].ovf;
    end

    // LOAD during a decimal conversion is dropped, not queued.
    do_load(8'd42, 1'b1);
    tick();
    tick();
    load = 1'b1;
    val  = 8'hFF;
    dec  = 1'b0;
    tick();
    load = 1'b0;
    wait_busy(cur_hi, cur_lo, cur_ovf, n);
    chk("collide_busy_len", n, 5);
    check_disp(7'b0110011, 7'b1101101, 1'b0, 2 * SD);

    // LOAD on the edge where BUSY falls is ignored.
    do_load(8'h11, 1'b0);
    chk("fall_busy_hi", busy, 1);
    load = 1'b1;
    val  = 8'h22;
    dec  = 1'b0;
    tick();
    load = 1'b0;
    chk("fall_busy_lo", busy, 0);
    tick();
    chk("fall_no_accept", busy, 0);
    check_disp(7'b0110000, 7'b0110000, 1'b0, 2 * SD);

    // Reset mid-conversion aborts with no partial result.
    do_load(8'd99, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("midreset");
    rst = 1'b0;
    check_disp(7'b0000000, 7'b0000000, 1'b0, 2 * SD);
    do_load(8'd5, 1'b1);
    wait_busy(7'b0000000, 7'b0000000, 1'b0, n);
    chk("post_reset_busy_len", n, 8);
    check_disp(7'b0000000, 7'b1011011, 1'b0, 2 * SD);

    scan_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
